// File: rtl/fs_rx_fifo.sv
//==============================================================================
// Module      : fs_rx_fifo
// Description : Receive byte FIFO between the fast-serial deserializer and an
//               Avalon-ST byte consumer. Bytes arrive as one-cycle strobes
//               with no backpressure; bytes that find the FIFO full are
//               dropped and flagged. The output is a registered head byte
//               refilled from a circular storage RAM.
//               Optional feature macro: FS_RX_FIFO_OVF_COUNT_EN enables the
//               16-bit saturating dropped-byte counter on o_ovf_count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fs_rx_fifo #(
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    // Deserializer side
    input  logic [7:0]            i_data,
    input  logic                  i_valid,
    // Avalon-ST source side
    output logic [7:0]            o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    // Status
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    input  logic                  i_clr_ovf,
    output logic [15:0]           o_ovf_count
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int                    c_DEPTH_N  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_DEPTH    = c_DEPTH_N[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   c_AFULL    = AFULL_LEVEL[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   c_LVL_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   c_LVL_ZERO = '0;
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = 1;

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    // Circular byte storage; contents are don't-care after reset.
    logic [7:0]            r_mem [0:c_DEPTH_N-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    // Head register presented on the Avalon-ST source.
    logic [7:0]            r_head;
    logic                  r_valid;
    // Total bytes held: storage plus head.
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_afull;
    logic                  r_ovf;

    //--------------------------------------------------------------------------
    // Combinational control
    //--------------------------------------------------------------------------
    logic                  w_pop;
    logic                  w_full;
    logic                  w_push;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_ram_cnt;
    logic                  w_load;
    logic [DEPTH_LOG2:0]   w_level_nxt;

    // A pop needs a held head byte; i_ready is ignored otherwise.
    assign w_pop     = r_valid & i_ready;
    assign w_full    = (r_level == c_DEPTH);
    // A full FIFO still accepts a byte when the head leaves on the same edge.
    assign w_push    = i_valid & (~w_full | w_pop);
    assign w_drop    = i_valid & w_full & ~w_pop;
    // Bytes sitting in storage, i.e. not yet moved into the head register.
    assign w_ram_cnt = r_level - {{DEPTH_LOG2{1'b0}}, r_valid};
    // The head refills only from bytes already in storage before this edge,
    // which gives a fresh byte one extra cycle before it becomes visible and
    // prevents any input-to-output bypass.
    assign w_load    = (~r_valid | w_pop) & (w_ram_cnt != c_LVL_ZERO);

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end
    end

    //--------------------------------------------------------------------------
    // Storage write port (no reset: RAM contents are irrelevant until written)
    //--------------------------------------------------------------------------
    // Write each accepted byte at the write pointer.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Write pointer advances per accepted byte and wraps modulo the depth.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        end
    end

    //--------------------------------------------------------------------------
    // Head register and read pointer
    //--------------------------------------------------------------------------
    // Refill the head from storage when it is empty or being consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head   <= 8'h00;
            r_valid  <= 1'b0;
            r_rd_ptr <= '0;
        end else if (w_load) begin
            r_head   <= r_mem[r_rd_ptr];
            r_valid  <= 1'b1;
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end else if (w_pop) begin
            r_valid  <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Occupancy and almost-full, registered on the push/pop edge itself
    //--------------------------------------------------------------------------
    // Level and almost-full both derive from the same next-level value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level <= '0;
            r_afull <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_afull <= (w_level_nxt >= c_AFULL);
        end
    end

    //--------------------------------------------------------------------------
    // Sticky overflow flag
    //--------------------------------------------------------------------------
    // A drop wins over a clear requested on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    //--------------------------------------------------------------------------
    // Optional dropped-byte counter
    //--------------------------------------------------------------------------
`ifdef FS_RX_FIFO_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    // Saturating count of drops; a drop on the clear edge restarts at 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf_count <= 16'h0000;
        end else if (i_clr_ovf) begin
            r_ovf_count <= w_drop ? 16'h0001 : 16'h0000;
        end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'h0001;
        end
    end

    assign o_ovf_count = r_ovf_count;
`else
    assign o_ovf_count = 16'h0000;
`endif

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign o_data        = r_head;
    assign o_valid       = r_valid;
    assign o_level       = r_level;
    assign o_almost_full = r_afull;
    assign o_overflow    = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_fs_rx_fifo.sv
`default_nettype none

module tb_fs_rx_fifo;

    localparam int DEPTH_LOG2  = 4;
    localparam int AFULL_LEVEL = 12;
    localparam int D           = 1 << DEPTH_LOG2;

    logic                i_clk;
    logic                i_rst_n;
    logic [7:0]          i_data;
    logic                i_valid;
    logic [7:0]          o_data;
    logic                o_valid;
    logic                i_ready;
    logic [DEPTH_LOG2:0] o_level;
    logic                o_almost_full;
    logic                o_overflow;
    logic                i_clr_ovf;
    logic [15:0]         o_ovf_count;

    fs_rx_fifo #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .AFULL_LEVEL (AFULL_LEVEL)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_level       (o_level),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .i_clr_ovf     (i_clr_ovf),
        .o_ovf_count   (o_ovf_count)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: every byte held, oldest first, plus whether the
    // oldest one is already visible at the output.
    logic [7:0] q[$];
    bit         m_hv;
    bit         m_ovf;
    int         m_cnt;

`ifdef FS_RX_FIFO_OVF_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hv  = 0;
        m_ovf = 0;
        m_cnt = 0;
    endtask

    // Apply one clock edge worth of the spec rules to the model.
    task automatic model_step(input bit v, input logic [7:0] d, input bit r, input bit c);
        bit pop, pushok, drop, hv_next;
        int old, waiting;
        pop     = m_hv && r;
        old     = q.size();
        pushok  = v && ((old < D) || pop);
        drop    = v && !pushok;
        // Bytes not yet visible before this edge; a byte arriving now is
        // never among them.
        waiting = old - (m_hv ? 1 : 0);
        hv_next = (m_hv && !pop) ? 1'b1 : (waiting > 0);
        if (pop) void'(q.pop_front());
        if (pushok) q.push_back(d);
        m_hv = hv_next;
        if (drop) m_ovf = 1;
        else if (c) m_ovf = 0;
        if (c) m_cnt = drop ? 1 : 0;
        else if (drop && m_cnt != 16'hFFFF) m_cnt++;
    endtask

    task automatic compare_all();
        chk("valid", {31'd0, o_valid}, {31'd0, m_hv});
        chk("level", 32'(o_level), 32'(q.size()));
        chk("afull", {31'd0, o_almost_full}, {31'd0, (q.size() >= AFULL_LEVEL)});
        chk("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
        chk("ovf_count", {16'd0, o_ovf_count}, CNT_EN ? 32'(m_cnt) : 32'd0);
        if (m_hv) chk("data", {24'd0, o_data}, {24'd0, q[0]});
    endtask

    // Drive one edge's inputs from a falling edge, then check at the next one.
    task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit c);
        i_valid   = v;
        i_data    = d;
        i_ready   = r;
        i_clr_ovf = c;
        @(posedge i_clk);
        model_step(v, d, r, c);
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_valid = 0; i_ready = 0; i_clr_ovf = 0; i_data = 8'h00;
        i_rst_n = 0;
        #1;
        model_reset();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_level", 32'(o_level), 32'd0);
        chk("rst_ovf", {31'd0, o_overflow}, 32'd0);
        chk("rst_data", {24'd0, o_data}, 32'd0);
        compare_all();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1;
    endtask

    logic [7:0] got[$];

    initial begin
        i_rst_n = 1; i_valid = 0; i_ready = 0; i_clr_ovf = 0; i_data = 0;
        model_reset();

        // Reset state and single byte latency
        do_reset();
        cycle(1, 8'hA5, 1, 0);
        chk("a5_edgeN_valid", {31'd0, o_valid}, 32'd0);
        chk("a5_edgeN_level", 32'(o_level), 32'd1);
        cycle(0, 8'h00, 1, 0);
        chk("a5_valid", {31'd0, o_valid}, 32'd1);
        chk("a5_data", {24'd0, o_data}, 32'hA5);
        cycle(0, 8'h00, 1, 0);
        chk("a5_level0", 32'(o_level), 32'd0);
        chk("a5_gone", {31'd0, o_valid}, 32'd0);

        // Fill, almost-full threshold, overflow
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1, 8'(i), 0, 0);
            if (i == 10) chk("afull_at11", {31'd0, o_almost_full}, 32'd0);
            if (i == 11) chk("afull_at12", {31'd0, o_almost_full}, 32'd1);
        end
        chk("full_level", 32'(o_level), 32'd16);
        cycle(1, 8'hFF, 0, 0);
        chk("drop_ovf", {31'd0, o_overflow}, 32'd1);
        chk("drop_cnt", {16'd0, o_ovf_count}, CNT_EN ? 32'd1 : 32'd0);
        chk("drop_level", 32'(o_level), 32'd16);
        cycle(0, 8'h00, 0, 1);
        chk("clr_ovf", {31'd0, o_overflow}, 32'd0);
        // Full with simultaneous push and pop
        chk("head_00", {24'd0, o_data}, 32'h00);
        cycle(1, 8'h10, 1, 0);
        chk("fullpp_level", 32'(o_level), 32'd16);
        chk("fullpp_ovf", {31'd0, o_overflow}, 32'd0);
        // Drop on the clear edge: drop wins
        cycle(1, 8'hEE, 0, 1);
        chk("clrdrop_ovf", {31'd0, o_overflow}, 32'd1);
        chk("clrdrop_cnt", {16'd0, o_ovf_count}, CNT_EN ? 32'd1 : 32'd0);
        // Drain: expect 0x01..0x10, neither 0xFF nor 0xEE
        got.delete();
        for (int k = 0; k < 40 && q.size() > 0; k++) begin
            if (o_valid) got.push_back(o_data);
            cycle(0, 8'h00, 1, 0);
        end
        chk("drain_count", 32'(got.size()), 32'd16);
        for (int k = 0; k < got.size() && k < 16; k++)
            chk("drain_byte", {24'd0, got[k]}, 32'(k + 1));

        // Continuous push with toggling ready, wrapping the pointers
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1, 8'(8'h40 + i), (i % 2) == 0, 0);
        for (int k = 0; k < 60 && q.size() > 0; k++) cycle(0, 8'h00, 1, 0);
        chk("wrap_empty", 32'(o_level), 32'd0);

        // Mid-stream reset discards stored bytes
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 8'(8'h80 + i), 0, 0);
        chk("pre_rst_level", 32'(o_level), 32'd5);
        do_reset();
        cycle(1, 8'h3C, 0, 0);
        cycle(0, 8'h00, 0, 0);
        chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
        chk("post_rst_first", {24'd0, o_data}, 32'h3C);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
